uart_rx_fifo: RTL

- Receive buffer directly downstream of the UART receiver in the clk_rx domain.
- Captures each good byte announced by rx_data_rdy into a first-word-fall-through FIFO, so the consumer (command parser / echo logic) need not service every byte inside one bit time.
- Discards bytes with framing errors, counts them, and flags overflow.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Ceiling log2 for pointer and occupancy widths; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 storage: one synchronous write port, asynchronous read.
// Entries are deliberately left unreset so this maps onto distributed RAM.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic                   clk_rx,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [UART_DATA_W-1:0] rd_data
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  // Write port: store the byte at the write pointer when enabled.
  always_ff @(posedge clk_rx) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word-fall-through FIFO of
// good bytes, framing-error event counter, sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  localparam int AW   = clog2(DEPTH),
  localparam int LW   = clog2(DEPTH) + 1
) (
  input  logic                   clk_rx,
  input  logic                   rst_clk_rx,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_data_rdy,
  input  logic                   frm_err,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] dout,
  output logic                   dout_vld,
  output logic                   full,
  output logic [LW-1:0]          level,
  output logic                   ovf,
  output logic [CNT_W-1:0]       frm_err_cnt,
  input  logic                   clr_err
);

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   frm_err_q;
  logic                   push_req, push_ok, pop, drop, frm_evt;
  logic [UART_DATA_W-1:0] rd_data;

  assign full     = (level_q == LW'(DEPTH));
  assign dout_vld = (level_q != '0);
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign frm_err_cnt = cnt_q;
  assign dout     = dout_vld ? rd_data : '0;

  // Qualify push/pop; a full FIFO accepts a push only when the head leaves in the same cycle.
  always_comb begin
    push_req = rx_data_rdy & ~frm_err;
    pop      = rd_en & dout_vld;
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    frm_evt  = frm_err & ~frm_err_q;
  end

  // Next-state for pointers, occupancy, overflow flag and error counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push_ok) level_d = level_q - LW'(1);
    // A new event in the clear cycle survives the clear.
    if (drop)         ovf_d = 1'b1;
    else if (clr_err) ovf_d = 1'b0;
    if (clr_err)                               cnt_d = frm_evt ? CNT_W'(1) : '0;
    else if (frm_evt && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers; reset flushes the FIFO and dominates all other inputs.
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      frm_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      frm_err_q <= frm_err;
    end
  end

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_rx  (clk_rx),
    .wr_en   (push_ok & ~rst_clk_rx),
    .wr_addr (wr_ptr_q),
    .wr_data (rx_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule
